// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator (640x480@60 by default).
//
// Produces the pixel-coordinate stream consumed by the renderers. Every output
// comes from one register stage, so coordinates and flags always agree.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   pix_en       pixel enable; counters and states advance only when high
//   hsync        horizontal sync, level SYNC_ACTIVE while asserted
//   vsync        vertical sync, level SYNC_ACTIVE while asserted
//   video_active high inside the visible area
//   pix_x        horizontal count, 0..H_TOTAL-1
//   pix_y        vertical count, 0..V_TOTAL-1
//   line_tick    one-clk pulse after each line wrap
//   frame_tick   one-clk pulse after each frame wrap
//   frame_count  frames since reset, wraps mod 1024
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_active,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       line_tick,
    output logic       frame_tick,
    output logic [9:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_START = 10'(H_VISIBLE);
    localparam logic [9:0] H_SY_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_BP_START = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START = 10'(V_VISIBLE);
    localparam logic [9:0] V_SY_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_BP_START = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {HVis, HFp, HSync, HBp} h_state_e;
    typedef enum logic [1:0] {VVis, VFp, VSync, VBp} v_state_e;

    h_state_e   h_state_q, h_state_d;
    v_state_e   v_state_q, v_state_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [9:0] frame_count_q, frame_count_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_active_q, video_active_d;
    logic       line_tick_q, line_tick_d;
    logic       frame_tick_q, frame_tick_d;

    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        h_state_d     = h_state_q;
        v_state_d     = v_state_q;
        frame_count_d = frame_count_q;
        line_tick_d   = 1'b0;
        frame_tick_d  = 1'b0;

        if (pix_en) begin
            if (x_q == H_LAST) begin
                x_d         = '0;
                line_tick_d = 1'b1;
                if (y_q == V_LAST) begin
                    y_d           = '0;
                    frame_tick_d  = 1'b1;
                    frame_count_d = frame_count_q + 10'd1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end

            // States change on the edge that enters the first count of a region,
            // so they are decoded from the next coordinate, not the current one.
            if (x_d == '0) begin
                h_state_d = HVis;
            end else if (x_d == H_FP_START) begin
                h_state_d = HFp;
            end else if (x_d == H_SY_START) begin
                h_state_d = HSync;
            end else if (x_d == H_BP_START) begin
                h_state_d = HBp;
            end

            // Vertical regions are whole lines, so only move on a line wrap.
            if (line_tick_d) begin
                if (y_d == '0) begin
                    v_state_d = VVis;
                end else if (y_d == V_FP_START) begin
                    v_state_d = VFp;
                end else if (y_d == V_SY_START) begin
                    v_state_d = VSync;
                end else if (y_d == V_BP_START) begin
                    v_state_d = VBp;
                end
            end
        end

        hsync_d        = (h_state_d == HSync) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d        = (v_state_d == VSync) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        video_active_d = (h_state_d == HVis) && (v_state_d == VVis);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_state_q      <= HVis;
            v_state_q      <= VVis;
            x_q            <= '0;
            y_q            <= '0;
            frame_count_q  <= '0;
            hsync_q        <= ~SYNC_ACTIVE;
            vsync_q        <= ~SYNC_ACTIVE;
            video_active_q <= 1'b1;
            line_tick_q    <= 1'b0;
            frame_tick_q   <= 1'b0;
        end else begin
            h_state_q      <= h_state_d;
            v_state_q      <= v_state_d;
            x_q            <= x_d;
            y_q            <= y_d;
            frame_count_q  <= frame_count_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            video_active_q <= video_active_d;
            line_tick_q    <= line_tick_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign video_active = video_active_q;
    assign pix_x        = x_q;
    assign pix_y        = y_q;
    assign line_tick    = line_tick_q;
    assign frame_tick   = frame_tick_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. Three instances share one clock:
//   0: default 640x480 timing, active-low sync
//   1: tiny H 8/2/2/2, V 4/1/1/1, active-high sync, reset mid-frame
//   2: minimal H 2/1/1/1, V 2/1/1/1, run past 1024 frames for the wrap
// The reference model derives every output from the number of enabled edges
// since reset using plain division/modulo.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [1:0] id;
        logic       hs;
        logic       vs;
        logic       va;
        logic [9:0] x;
        logic [9:0] y;
        logic       lt;
        logic       ft;
        logic [9:0] fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst[3];
    logic       en[3];
    logic       hs[3];
    logic       vs[3];
    logic       va[3];
    logic [9:0] px[3];
    logic [9:0] py[3];
    logic       lt[3];
    logic       ft[3];
    logic [9:0] fc[3];

    longint     n[3];
    exp_t       sb_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut0 (
        .clk(clk), .rst_n(rst[0]), .pix_en(en[0]), .hsync(hs[0]), .vsync(vs[0]),
        .video_active(va[0]), .pix_x(px[0]), .pix_y(py[0]), .line_tick(lt[0]),
        .frame_tick(ft[0]), .frame_count(fc[0])
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_ACTIVE(1'b1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst[1]), .pix_en(en[1]), .hsync(hs[1]), .vsync(vs[1]),
        .video_active(va[1]), .pix_x(px[1]), .pix_y(py[1]), .line_tick(lt[1]),
        .frame_tick(ft[1]), .frame_count(fc[1])
    );

    vga_timing_gen #(
        .H_VISIBLE(2), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_ACTIVE(1'b0)
    ) u_dut2 (
        .clk(clk), .rst_n(rst[2]), .pix_en(en[2]), .hsync(hs[2]), .vsync(vs[2]),
        .video_active(va[2]), .pix_x(px[2]), .pix_y(py[2]), .line_tick(lt[2]),
        .frame_tick(ft[2]), .frame_count(fc[2])
    );

    // Expected outputs after n enabled edges; te marks that the last edge advanced.
    function automatic exp_t model(input int id, input longint cnt, input bit te);
        longint hv, hf, hsw, hb, vv, vf, vsw, vb;
        longint ht, vt, x, line, y, f;
        bit     sa;
        exp_t   e;
        case (id)
            0: begin
                hv = 640; hf = 16; hsw = 96; hb = 48; vv = 480; vf = 10; vsw = 2; vb = 33;
                sa = 1'b0;
            end
            1: begin
                hv = 8; hf = 2; hsw = 2; hb = 2; vv = 4; vf = 1; vsw = 1; vb = 1; sa = 1'b1;
            end
            default: begin
                hv = 2; hf = 1; hsw = 1; hb = 1; vv = 2; vf = 1; vsw = 1; vb = 1; sa = 1'b0;
            end
        endcase
        ht   = hv + hf + hsw + hb;
        vt   = vv + vf + vsw + vb;
        x    = cnt % ht;
        line = cnt / ht;
        y    = line % vt;
        f    = (line / vt) % 1024;
        e.id = 2'(id);
        e.hs = (x >= hv + hf && x < hv + hf + hsw) ? sa : ~sa;
        e.vs = (y >= vv + vf && y < vv + vf + vsw) ? sa : ~sa;
        e.va = (x < hv) && (y < vv);
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.lt = te && (x == 0);
        e.ft = te && (x == 0) && (y == 0);
        e.fc = 10'(f);
        return e;
    endfunction

    function automatic exp_t actual(input int id);
        exp_t a;
        a.id = 2'(id);
        a.hs = hs[id];
        a.vs = vs[id];
        a.va = va[id];
        a.x  = px[id];
        a.y  = py[id];
        a.lt = lt[id];
        a.ft = ft[id];
        a.fc = fc[id];
        return a;
    endfunction

    task automatic compare(input string name, input exp_t e);
        exp_t a;
        a = actual(int'(e.id));
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s dut%0d @%0t: got x=%0d y=%0d hs=%b vs=%b va=%b lt=%b ft=%b fc=%0d, want x=%0d y=%0d hs=%b vs=%b va=%b lt=%b ft=%b fc=%0d",
                     name, e.id, $time, a.x, a.y, a.hs, a.vs, a.va, a.lt, a.ft, a.fc,
                     e.x, e.y, e.hs, e.vs, e.va, e.lt, e.ft, e.fc);
        end
    endtask

    // Monitor: pops expectations away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                compare("scoreboard", e);
            end
        end
    end

    // Driver + model: records the response implied by the edge just taken.
    initial begin
        bit      te[3];
        bit      did_rst = 1'b0;
        int      rst_hold = 0;
        // Mid-frame point for dut1: frame 5, line 3, pixel 5.
        longint  target = 5 * 98 + 3 * 14 + 5;

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0;
            en[i]  = 1'b0;
            n[i]   = 0;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) sb_q.push_back(model(i, 0, 1'b0));
        end
        for (int i = 0; i < 3; i++) rst[i] = 1'b1;
        for (int i = 0; i < 3; i++) en[i] = 1'b1;

        for (int cyc = 0; cyc < 32000; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                te[i] = rst[i] && en[i];
                if (te[i]) n[i]++;
            end

            if (!did_rst && n[1] == target) begin
                did_rst = 1'b1;
                rst[1]  = 1'b0;
                #1;
                compare("async_reset", model(1, 0, 1'b0));
                n[1]     = 0;
                te[1]    = 1'b0;
                rst_hold = 3;
            end

            for (int i = 0; i < 3; i++) sb_q.push_back(model(i, n[i], te[i]));

            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst[1] = 1'b1;
            end

            if (cyc < 1700) en[0] = 1'b1;
            else if (cyc < 5100) en[0] = (cyc % 2 == 1);
            else en[0] = ($urandom_range(0, 3) != 0);
            en[1] = ($urandom_range(0, 9) < 7);
            en[2] = ($urandom_range(0, 19) != 0);
        end

        @(negedge clk);
        #1;
        if (!did_rst || n[2] < 1025 * 25) begin
            miscompares++;
            $display("FAIL coverage: reset_done=%0b dut2_edges=%0d, want 1 and >= %0d",
                     did_rst, n[2], 1025 * 25);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
